// File: rtl/mrf_spi_target.sv
// ---------------------------------------------------------------------------
// mrf_spi_target
//   SPI responder for the MRF24J40-style short/long register protocol.
//   Holds a short and a long 8-bit register bank. Both banks are reachable
//   from the SPI master and from a local register port. Every SPI write is
//   reported on wr_evt/wr_addr/wr_data. All SPI lines are oversampled by clk,
//   which must run at 8x sck or faster.
//
//   Optional feature: define MRF_SPI_TGT_INTR_EN to get a sticky write
//   interrupt (intr, cleared by intr_clr). Without it, intr is tied to 0.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   sck, cs, sdi    SPI from the master (cs active-low, MSB first)
//   sdo             SPI to the master, driven only in a read data phase
//   loc_addr        local address {long_sel, addr[9:0]}; short uses [5:0]
//   loc_we/wdata    local write request; held until loc_ready
//   loc_ready       low only in the clk of an SPI commit (SPI wins)
//   loc_rdata       registered read of loc_addr, 1-clk latency
//   wr_evt          1-clk pulse on an SPI write commit
//   wr_addr/wr_data address/data of the last SPI write
//   intr, intr_clr  sticky write interrupt and its clear
// ---------------------------------------------------------------------------
module mrf_spi_target #(
    parameter int SHORT_DEPTH = 64,
    parameter int LONG_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        cs,
    input  logic        sdi,
    output logic        sdo,
    input  logic [10:0] loc_addr,
    input  logic        loc_we,
    input  logic [7:0]  loc_wdata,
    output logic        loc_ready,
    output logic [7:0]  loc_rdata,
    output logic        wr_evt,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        intr,
    input  logic        intr_clr
);

    localparam int SAW = (SHORT_DEPTH > 1) ? $clog2(SHORT_DEPTH) : 1;
    localparam int LAW = (LONG_DEPTH  > 1) ? $clog2(LONG_DEPTH)  : 1;
    localparam logic [6:0]  SHORT_LIM = 7'(SHORT_DEPTH);
    localparam logic [10:0] LONG_LIM  = 11'(LONG_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_TURN, S_DATA, S_DONE} state_t;

    // ---------------- register banks ----------------
    logic [7:0] short_mem [SHORT_DEPTH];
    logic [7:0] long_mem  [LONG_DEPTH];

    function automatic logic is_impl(input logic [10:0] a);
        if (a[10]) return ({1'b0, a[9:0]} < LONG_LIM);
        else       return ({1'b0, a[5:0]} < SHORT_LIM);
    endfunction

    // Unimplemented locations read as zero.
    function automatic logic [7:0] rd_bank(input logic [10:0] a);
        if (!is_impl(a)) return 8'h00;
        else if (a[10])  return long_mem[a[LAW-1:0]];
        else             return short_mem[a[SAW-1:0]];
    endfunction

    // ---------------- synchronisers / edge detect ----------------
    logic [1:0] sck_sq, cs_sq, sdi_sq;
    logic       sck_prev_q, cs_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sq     <= 2'b00;
            cs_sq      <= 2'b11;   // deselected, so reset never fakes a cs fall
            sdi_sq     <= 2'b00;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sq     <= {sck_sq[0], sck};
            cs_sq      <= {cs_sq[0], cs};
            sdi_sq     <= {sdi_sq[0], sdi};
            sck_prev_q <= sck_sq[1];
            cs_prev_q  <= cs_sq[1];
        end
    end

    logic sck_rise, cs_fall, cs_rise, bit_stb, sdi_s;
    assign sck_rise = sck_sq[1] & ~sck_prev_q;
    assign cs_fall  = cs_prev_q & ~cs_sq[1];
    assign cs_rise  = ~cs_prev_q & cs_sq[1];
    assign bit_stb  = sck_rise & ~cs_sq[1];
    assign sdi_s    = sdi_sq[1];   // same delay as sck, so aligned with bit_stb

    // ---------------- frame FSM ----------------
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;   // bit index within the frame
    logic [10:0] sr_q, sr_d;             // header / data shift register
    logic [10:0] addr_q, addr_d;         // {long_sel, addr}
    logic        rw_q, rw_d;
    logic [7:0]  rd_byte_q, rd_byte_d;
    logic        sdo_q, sdo_d;
    logic        commit_q, commit_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            rd_byte_q <= '0;
            sdo_q     <= 1'b0;
            commit_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            rd_byte_q <= rd_byte_d;
            sdo_q     <= sdo_d;
            commit_q  <= commit_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        rd_byte_d = rd_byte_q;
        commit_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fetch     = 1'b0;
        sdo_d     = 1'b0;

        if (cs_rise) begin
            // Deselect aborts anything in flight; a partial write never commits.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_HDR;
                        bit_cnt_d = '0;
                        sr_d      = '0;
                    end
                end
                S_HDR: begin
                    if (bit_stb) begin
                        sr_d      = {sr_q[9:0], sdi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        // sr_q still holds the bits before the current one:
                        // b0 (long flag) sits at sr_q[6] at bit 7, sr_q[10] at bit 11.
                        if (bit_cnt_q == 5'd7 && !sr_q[6]) begin
                            addr_d  = {5'b0, sr_q[5:0]};
                            rw_d    = sdi_s;
                            fetch   = 1'b1;
                            state_d = S_DATA;
                        end else if (bit_cnt_q == 5'd11 && sr_q[10]) begin
                            addr_d  = {1'b1, sr_q[9:0]};
                            rw_d    = sdi_s;
                            fetch   = 1'b1;
                            state_d = S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    if (bit_stb) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_stb) begin
                        sr_d      = {sr_q[9:0], sdi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        // Data starts at bit 8 (short) or 16 (long), so the
                        // low three count bits are the data-bit index.
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            state_d = S_DONE;
                            if (rw_q) begin
                                commit_d  = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = {sr_q[6:0], sdi_s};
                            end
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end

        // Snapshot at header completion; a local write in the same clk lands
        // after this read, so the master sees the old value.
        if (fetch) rd_byte_d = rd_bank(addr_d);

        // sdo is computed from next-state so it moves in the same clk as the
        // bit strobe, well before the master's sampling falling edge.
        if (state_d == S_DATA && !rw_d) sdo_d = rd_byte_d[~bit_cnt_d[2:0]];
    end

    // ---------------- bank write port ----------------
    // The SPI commit owns the port for one clk; the local requester holds
    // loc_we through that clk and is accepted in the next.
    logic        bw_en;
    logic [10:0] bw_addr;
    logic [7:0]  bw_data;

    assign bw_en   = commit_q | loc_we;
    assign bw_addr = commit_q ? wr_addr_q : loc_addr;
    assign bw_data = commit_q ? wr_data_q : loc_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHORT_DEPTH; i++) short_mem[i] <= 8'h00;
            for (int i = 0; i < LONG_DEPTH; i++)  long_mem[i]  <= 8'h00;
        end else if (bw_en && is_impl(bw_addr)) begin
            if (bw_addr[10]) long_mem[bw_addr[LAW-1:0]]  <= bw_data;
            else             short_mem[bw_addr[SAW-1:0]] <= bw_data;
        end
    end

    logic [7:0] loc_rdata_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) loc_rdata_q <= 8'h00;
        else     loc_rdata_q <= rd_bank(loc_addr);
    end

    // ---------------- interrupt ----------------
`ifdef MRF_SPI_TGT_INTR_EN
    logic intr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           intr_q <= 1'b0;
        else if (commit_q) intr_q <= 1'b1;   // a new write beats a clear
        else if (intr_clr) intr_q <= 1'b0;
    end
    assign intr = intr_q;
`else
    logic unused_intr_clr;
    assign unused_intr_clr = intr_clr;
    assign intr = 1'b0;
`endif

    assign sdo       = sdo_q;
    assign loc_ready = ~commit_q;
    assign loc_rdata = loc_rdata_q;
    assign wr_evt    = commit_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mrf_spi_target.sv
`timescale 1ns/1ps
module tb_mrf_spi_target;

    localparam int LD   = 64;
    localparam int HALF = 80;   // half sck period = 8 clk

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0, cs = 1'b1, sdi = 1'b0;
    logic        sdo;
    logic [10:0] loc_addr = '0;
    logic        loc_we = 1'b0;
    logic [7:0]  loc_wdata = '0;
    logic        loc_ready;
    logic [7:0]  loc_rdata;
    logic        wr_evt;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        intr;
    logic        intr_clr = 1'b0;

    int checks = 0, failures = 0, evt_cnt = 0;

    logic [7:0] sm [64];
    logic [7:0] lm [1024];

    always #5 clk = ~clk;

    mrf_spi_target dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo),
        .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata),
        .loc_ready(loc_ready), .loc_rdata(loc_rdata), .wr_evt(wr_evt),
        .wr_addr(wr_addr), .wr_data(wr_data), .intr(intr), .intr_clr(intr_clr)
    );

    always @(negedge clk) if (!rst && wr_evt === 1'b1) evt_cnt++;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 64; i++)   sm[i] = 8'h00;
        for (int i = 0; i < 1024; i++) lm[i] = 8'h00;
    endtask

    function automatic logic [7:0] model_rd(input logic lng, input logic [9:0] a);
        if (lng) return (a < LD) ? lm[a] : 8'h00;
        return sm[a[5:0]];
    endfunction

    task automatic model_wr(input logic lng, input logic [9:0] a, input logic [7:0] d);
        if (lng) begin if (a < LD) lm[a] = d; end
        else sm[a[5:0]] = d;
    endtask

    // ---------------- drivers ----------------
    // Master sends nbits of the frame; samples sdo on the falling edges from
    // the last header/turnaround bit through data bit 6.
    task automatic spi_frame(input logic lng, input logic [9:0] a, input logic wr,
                             input logic [7:0] wd, input int nbits, input logic hold,
                             output logic [7:0] rd);
        logic [23:0] f;
        int tot, base;
        rd = 8'h00;
        if (lng) begin f = {1'b1, a, wr, 4'b0000, wd}; tot = 24; base = 16; end
        else     begin f = {1'b0, a[5:0], wr, wd, 8'h00}; tot = 16; base = 8; end
        @(negedge clk); #2;
        cs = 1'b0; #HALF;
        for (int i = 0; i < nbits && i < tot; i++) begin
            sdi = f[23-i]; #HALF;
            sck = 1'b1;    #HALF;
            sck = 1'b0;
            if (i >= base-1 && i <= base+6) rd = {rd[6:0], sdo};
        end
        sdi = 1'b0; #HALF;
        if (!hold) begin cs = 1'b1; #(4*HALF); end
    endtask

    task automatic loc_write(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        for (int k = 0; k < 8 && !loc_ready; k++) @(negedge clk);
        @(negedge clk);
        loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [10:0] a, output logic [7:0] d);
        @(negedge clk); loc_addr = a;
        @(negedge clk); d = loc_rdata;
    endtask

    // write via SPI and check the event report against the model
    task automatic spi_write_chk(input string nm, input logic lng, input logic [9:0] a,
                                 input logic [7:0] d);
        logic [7:0] rd;
        logic [10:0] ea;
        int e0;
        e0 = evt_cnt;
        ea = lng ? {1'b1, a} : {5'b0, a[5:0]};
        spi_frame(lng, a, 1'b1, d, 24, 1'b0, rd);
        model_wr(lng, a, d);
        checks++;
        if (evt_cnt !== e0 + 1) begin failures++; $display("FAIL %s_evt: got %0d pulses, expected 1", nm, evt_cnt - e0); end
        checks++;
        if (wr_addr !== ea) begin failures++; $display("FAIL %s_addr: got %h expected %h", nm, wr_addr, ea); end
        checks++;
        if (wr_data !== d) begin failures++; $display("FAIL %s_data: got %h expected %h", nm, wr_data, d); end
    endtask

    task automatic spi_read_chk(input string nm, input logic lng, input logic [9:0] a);
        logic [7:0] rd, exp;
        int e0;
        e0 = evt_cnt;
        exp = model_rd(lng, a);
        spi_frame(lng, a, 1'b0, 8'h00, 24, 1'b0, rd);
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL %s: read %h at %h got %h expected %h", nm, lng, a, rd, exp); end
        checks++;
        if (evt_cnt !== e0) begin failures++; $display("FAIL %s_noevt: got %0d pulses, expected 0", nm, evt_cnt - e0); end
    endtask

    task automatic loc_read_chk(input string nm, input logic lng, input logic [9:0] a);
        logic [7:0] d, exp;
        exp = model_rd(lng, a);
        loc_read({lng, a}, d);
        checks++;
        if (d !== exp) begin failures++; $display("FAIL %s: loc_rdata %h got %h expected %h", nm, {lng, a}, d, exp); end
    endtask

    task automatic chk_reset_outs(input string nm);
        checks++;
        if ({sdo, loc_ready, loc_rdata, wr_evt, wr_addr, wr_data, intr} !== {1'b0, 1'b1, 8'h00, 1'b0, 11'h000, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL %s: sdo=%b rdy=%b rdata=%h evt=%b waddr=%h wdata=%h intr=%b, expected 0 1 00 0 000 00 0",
                     nm, sdo, loc_ready, loc_rdata, wr_evt, wr_addr, wr_data, intr);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_clear();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_outs("reset_in");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_outs("reset_after");
        loc_read_chk("reset_bank_short", 1'b0, 10'(($urandom_range(0, 63))));
        loc_read_chk("reset_bank_long",  1'b1, 10'(($urandom_range(0, 63))));
    endtask

    task automatic test_short_write();
        spi_write_chk("short_wr", 1'b0, 10'h012, 8'hA5);
        loc_read_chk("short_wr_readback", 1'b0, 10'h012);
    endtask

    task automatic test_long_read();
        loc_write(11'h43A, 8'h3C);
        model_wr(1'b1, 10'h03A, 8'h3C);
        spi_read_chk("long_rd_3A", 1'b1, 10'h03A);
        spi_read_chk("short_rd_12", 1'b0, 10'h012);
    endtask

    task automatic test_abort();
        logic [7:0] rd, v;
        int e0;
        v = 8'($urandom_range(1, 255));
        loc_write(11'h005, v);
        model_wr(1'b0, 10'h005, v);
        e0 = evt_cnt;
        spi_frame(1'b0, 10'h005, 1'b1, ~v, 12, 1'b0, rd);
        checks++;
        if (evt_cnt !== e0) begin failures++; $display("FAIL abort_noevt: got %0d pulses expected 0", evt_cnt - e0); end
        loc_read_chk("abort_unchanged", 1'b0, 10'h005);
        spi_read_chk("abort_next_rd", 1'b0, 10'h005);
        spi_write_chk("abort_next_wr", 1'b0, 10'h006, 8'h5A);
    endtask

    task automatic test_collision();
        logic [7:0] rd, x, y;
        logic got;
        x = 8'($urandom); y = ~x;
        fork
            spi_frame(1'b0, 10'h020, 1'b1, x, 16, 1'b0, rd);
            begin
                got = 1'b0;
                for (int k = 0; k < 2000 && !got; k++) begin
                    @(negedge clk);
                    if (wr_evt === 1'b1) got = 1'b1;
                end
                checks++;
                if (!got) begin failures++; $display("FAIL collision_evt: no wr_evt within 2000 clk, expected one"); end
                else begin
                    loc_addr = 11'h020; loc_wdata = y; loc_we = 1'b1;
                    checks++;
                    if (loc_ready !== 1'b0) begin failures++; $display("FAIL collision_busy: loc_ready=%b expected 0", loc_ready); end
                    @(negedge clk);
                    checks++;
                    if (loc_ready !== 1'b1) begin failures++; $display("FAIL collision_accept: loc_ready=%b expected 1", loc_ready); end
                    @(negedge clk);
                    loc_we = 1'b0;
                end
            end
        join
        model_wr(1'b0, 10'h020, y);
        checks++;
        if (wr_data !== x) begin failures++; $display("FAIL collision_wdata: got %h expected %h", wr_data, x); end
        loc_read_chk("collision_final", 1'b0, 10'h020);
    endtask

    task automatic test_unimpl();
        spi_write_chk("unimpl_wr", 1'b1, 10'h3FF, 8'($urandom_range(1, 255)));
        spi_read_chk("unimpl_rd", 1'b1, 10'h3FF);
        loc_read_chk("unimpl_loc", 1'b1, 10'h3FF);
        spi_write_chk("edge_wr_3F", 1'b1, 10'h03F, 8'hC3);
        spi_read_chk("edge_rd_3F", 1'b1, 10'h03F);
        spi_write_chk("edge_wr_40", 1'b1, 10'h040, 8'h81);
        spi_read_chk("edge_rd_40", 1'b1, 10'h040);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        d = 8'($urandom);
        spi_write_chk("b2b_wr", 1'b0, 10'h02A, d);
        spi_read_chk("b2b_rd", 1'b0, 10'h02A);
        spi_write_chk("b2b_wr_long", 1'b1, 10'h011, ~d);
        spi_read_chk("b2b_rd_long", 1'b1, 10'h011);
    endtask

    task automatic test_random();
        logic lng, wr;
        logic [9:0] a;
        logic [7:0] d;
        for (int n = 0; n < 24; n++) begin
            lng = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = lng ? 10'($urandom_range(48, 79)) : 10'($urandom_range(0, 15));
            d   = 8'($urandom);
            if (wr) spi_write_chk("rand_wr", lng, a, d);
            else    spi_read_chk("rand_rd", lng, a);
            if (n % 4 == 3) begin
                lng = 1'($urandom_range(0, 1));
                a   = lng ? 10'($urandom_range(48, 79)) : 10'($urandom_range(0, 15));
                d   = 8'($urandom);
                loc_write({lng, a}, d);
                model_wr(lng, a, d);
            end
        end
        for (int n = 0; n < 8; n++) begin
            lng = 1'($urandom_range(0, 1));
            a   = lng ? 10'($urandom_range(48, 79)) : 10'($urandom_range(0, 15));
            loc_read_chk("rand_loc", lng, a);
        end
    endtask

    task automatic test_intr();
`ifdef MRF_SPI_TGT_INTR_EN
        @(negedge clk); intr_clr = 1'b1;
        @(negedge clk); intr_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (intr !== 1'b0) begin failures++; $display("FAIL intr_preclear: got %b expected 0", intr); end
        spi_write_chk("intr_wr1", 1'b0, 10'h030, 8'h11);
        spi_write_chk("intr_wr2", 1'b0, 10'h031, 8'h22);
        repeat (10) @(negedge clk);
        checks++;
        if (intr !== 1'b1) begin failures++; $display("FAIL intr_set: got %b expected 1", intr); end
        intr_clr = 1'b1;
        @(negedge clk); intr_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (intr !== 1'b0) begin failures++; $display("FAIL intr_clr: got %b expected 0", intr); end
`else
        spi_write_chk("intr_wr1", 1'b0, 10'h030, 8'h11);
        intr_clr = 1'b1;
        spi_write_chk("intr_wr2", 1'b0, 10'h031, 8'h22);
        intr_clr = 1'b0;
        checks++;
        if (intr !== 1'b0) begin failures++; $display("FAIL intr_tied: got %b expected 0", intr); end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rd;
        loc_write(11'h410, 8'hFF);
        model_wr(1'b1, 10'h010, 8'hFF);
        @(negedge clk); loc_addr = 11'h410;
        // 19 bits: into the data phase of a read, cs left low
        spi_frame(1'b1, 10'h010, 1'b0, 8'h00, 19, 1'b1, rd);
        checks++;
        if (sdo !== 1'b1) begin failures++; $display("FAIL midframe_sdo: got %b expected 1", sdo); end
        checks++;
        if (loc_rdata !== 8'hFF) begin failures++; $display("FAIL midframe_rdata: got %h expected ff", loc_rdata); end
        #3 rst = 1'b1;
        #1 chk_reset_outs("midframe_rst");
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        chk_reset_outs("midframe_after");
        loc_read_chk("midframe_bank", 1'b1, 10'h010);
        spi_write_chk("midframe_next_wr", 1'b0, 10'h007, 8'h77);
        spi_read_chk("midframe_next_rd", 1'b0, 10'h007);
    endtask

    initial begin
        test_reset();
        test_short_write();
        test_long_read();
        test_abort();
        test_collision();
        test_unimpl();
        test_back_to_back();
        test_random();
        test_intr();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
